// File: rtl/keyentry_fsm_if.sv
// keyentry_fsm_if: signal bundle between the keypad/button front end and
// the key-entry control FSM.
//   one_second    : once-per-second single-cycle pulse
//   key           : debounced keypad code (NOKEY when released)
//   alarm_button  : level, high while pressed
//   time_button   : level, high while pressed
//   shift         : one-cycle strobe into the key shift register
//   show_new_time : display shows the key buffer
//   show_a        : display shows the alarm time
//   load_new_a    : one-cycle strobe, key buffer -> alarm register
//   load_new_c    : one-cycle strobe, key buffer -> time counter
// master = stimulus/front-end side, slave = the FSM.
interface keyentry_fsm_if;
    logic       one_second;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
    logic       shift;
    logic       show_new_time;
    logic       show_a;
    logic       load_new_a;
    logic       load_new_c;

    modport master (
        output one_second, key, alarm_button, time_button,
        input  shift, show_new_time, show_a, load_new_a, load_new_c
    );

    modport slave (
        input  one_second, key, alarm_button, time_button,
        output shift, show_new_time, show_a, load_new_a, load_new_c
    );
endinterface

// File: rtl/keyentry_fsm.sv
// keyentry_fsm: Moore control FSM in front of the 4-digit key shift
// register. Issues exactly one shift per key press, drives the display
// select and the alarm/time load strobes, and abandons key entry after
// TIMEOUT_SEC one_second pulses of inactivity.
// Ports:
//   clock : rising-edge system clock
//   reset : asynchronous, active-high; forces SHOW_TIME, clears the timer
//   kif   : keyentry_fsm_if.slave (inputs key/buttons/one_second,
//           registered outputs shift/show_new_time/show_a/load_new_a/c)
module keyentry_fsm #(
    parameter logic [3:0] NOKEY       = 4'd10,
    parameter int         TIMEOUT_SEC = 10
) (
    input  logic           clock,
    input  logic           reset,
    keyentry_fsm_if.slave  kif
);

    localparam logic [3:0] TIMEOUT_VAL = 4'(TIMEOUT_SEC);

    typedef enum logic [2:0] {
        SHOW_TIME        = 3'd0,
        KEY_STORED       = 3'd1,
        KEY_WAITED       = 3'd2,
        KEY_ENTRY        = 3'd3,
        SHOW_ALARM       = 3'd4,
        SET_ALARM_TIME   = 3'd5,
        SET_CURRENT_TIME = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] timer_q, timer_d;
    logic       shift_q, shift_d;
    logic       show_new_time_q, show_new_time_d;
    logic       show_a_q, show_a_d;
    logic       load_new_a_q, load_new_a_d;
    logic       load_new_c_q, load_new_c_d;
    logic       timeout;
    logic       key_pressed;

    // Codes 11-15 count as presses: only NOKEY means "released".
    assign key_pressed = (kif.key != NOKEY);
    assign timeout     = (timer_q == TIMEOUT_VAL);

    always_comb begin
        state_d = state_q;
        timer_d = '0;

        // The timer only runs while waiting for key activity; every other
        // state (KEY_STORED included) clears it, so each key restarts it.
        if (state_q == KEY_WAITED || state_q == KEY_ENTRY) begin
            timer_d = (kif.one_second && !timeout) ? timer_q + 4'd1 : timer_q;
        end

        case (state_q)
            SHOW_TIME: begin
                if (kif.alarm_button)  state_d = SHOW_ALARM;
                else if (key_pressed)  state_d = KEY_STORED;
            end
            KEY_STORED: state_d = KEY_WAITED;
            KEY_WAITED: begin
                // A held key never re-shifts: must see NOKEY first.
                if (!key_pressed)      state_d = KEY_ENTRY;
                else if (timeout)      state_d = SHOW_TIME;
            end
            KEY_ENTRY: begin
                // Buttons outrank keys; alarm outranks time.
                if (kif.alarm_button)     state_d = SET_ALARM_TIME;
                else if (kif.time_button) state_d = SET_CURRENT_TIME;
                else if (timeout)         state_d = SHOW_TIME;
                else if (key_pressed)     state_d = KEY_STORED;
            end
            SHOW_ALARM: begin
                if (!kif.alarm_button) state_d = SHOW_TIME;
            end
            SET_ALARM_TIME:   state_d = SHOW_TIME;
            SET_CURRENT_TIME: state_d = SHOW_TIME;
            default:          state_d = SHOW_TIME;
        endcase

        // Outputs are decoded from the next state and registered, so they
        // always equal the decode of state_q with no input-to-output path.
        shift_d         = (state_d == KEY_STORED);
        show_new_time_d = (state_d == KEY_STORED) || (state_d == KEY_WAITED) ||
                          (state_d == KEY_ENTRY);
        show_a_d        = (state_d == SHOW_ALARM);
        load_new_a_d    = (state_d == SET_ALARM_TIME);
        load_new_c_d    = (state_d == SET_CURRENT_TIME);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= SHOW_TIME;
            timer_q         <= '0;
            shift_q         <= 1'b0;
            show_new_time_q <= 1'b0;
            show_a_q        <= 1'b0;
            load_new_a_q    <= 1'b0;
            load_new_c_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            shift_q         <= shift_d;
            show_new_time_q <= show_new_time_d;
            show_a_q        <= show_a_d;
            load_new_a_q    <= load_new_a_d;
            load_new_c_q    <= load_new_c_d;
        end
    end

    assign kif.shift         = shift_q;
    assign kif.show_new_time = show_new_time_q;
    assign kif.show_a        = show_a_q;
    assign kif.load_new_a    = load_new_a_q;
    assign kif.load_new_c    = load_new_c_q;

endmodule

// File: doc/keyentry_fsm.md
Name: keyentry_fsm

Overview:
Control FSM that sits directly upstream of the 4-digit key shift register. It watches the debounced keypad code and the time/alarm buttons, and issues a single-cycle `shift` per key press. It also drives the display-select and load strobes (new alarm, new current time) consumed by the alarm register, display mux and time counter. A per-second inactivity timer abandons key entry and returns to normal time display.

Parameters:
- NOKEY, 4'd10, keypad code meaning "no key pressed"; codes 0-9 are digits, 11-15 are never driven by the keypad.
- TIMEOUT_SEC, 10, one_second pulses of inactivity before key entry is abandoned (range 2-15).

Ports:
- clock  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high; forces SHOW_TIME and clears the timer
- one_second  input  1  single-cycle pulse, once per second
- key  input  4  debounced keypad code; held for the whole press, NOKEY when released
- alarm_button  input  1  level, high while pressed
- time_button  input  1  level, high while pressed
- shift  output  1  one-cycle strobe to the key register; shift in `key`
- show_new_time  output  1  display shows the key buffer
- show_a  output  1  display shows the alarm time
- load_new_a  output  1  one-cycle strobe; load key buffer into the alarm register
- load_new_c  output  1  one-cycle strobe; load key buffer into the time counter

Behaviour:
- Moore machine. All outputs decode from the state register only; there is no input-to-output combinational path.
- States: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM, SET_ALARM_TIME, SET_CURRENT_TIME.
- Reset (asynchronous, any time, including mid-entry):
  - state = SHOW_TIME, timer = 0.
  - All outputs 0 while reset is high and in the first cycle after release.
- Output decode:
  - shift=1 only in KEY_STORED.
  - show_new_time=1 in KEY_STORED, KEY_WAITED and KEY_ENTRY.
  - show_a=1 only in SHOW_ALARM.
  - load_new_a=1 only in SET_ALARM_TIME.
  - load_new_c=1 only in SET_CURRENT_TIME.
  - All other outputs are 0.
- Transitions, evaluated each rising clock edge. Within a state, the first matching rule wins.
  - SHOW_TIME: alarm_button -> SHOW_ALARM; else key!=NOKEY -> KEY_STORED; else stay.
  - KEY_STORED: unconditionally -> KEY_WAITED, so exactly one shift per press.
  - KEY_WAITED: key==NOKEY -> KEY_ENTRY; else timeout -> SHOW_TIME; else stay. A key held indefinitely never produces a second shift.
  - KEY_ENTRY: alarm_button -> SET_ALARM_TIME; else time_button -> SET_CURRENT_TIME; else timeout -> SHOW_TIME; else key!=NOKEY -> KEY_STORED; else stay.
  - SHOW_ALARM: alarm_button==0 -> SHOW_TIME; else stay. Keys are ignored here.
  - SET_ALARM_TIME, SET_CURRENT_TIME: unconditionally -> SHOW_TIME, giving one-cycle strobes.
- Timer:
  - 4-bit counter.
  - Cleared in every state other than KEY_WAITED and KEY_ENTRY, so entering KEY_STORED restarts the timeout for each key.
  - In KEY_WAITED and KEY_ENTRY it increments on one_second, saturating at TIMEOUT_SEC.
  - timeout = (timer == TIMEOUT_SEC).
  - The state change happens on the edge after timeout goes high.
- Simultaneous events:
  - Button and key together in KEY_ENTRY: the button wins.
  - alarm_button and time_button together: alarm wins.
  - one_second in the same cycle as the KEY_STORED transition: the count is discarded, because the timer is cleared.
- Out-of-range key codes 11-15 are treated as key presses (not NOKEY).
- Illegal or unreachable state encodings go to SHOW_TIME on the next edge.

Test Plan:
- Reset for 5 cycles, then release with key=NOKEY and buttons low -> all outputs 0, state SHOW_TIME, held for 20 cycles.
- Idle, then key=4'd3 held 8 cycles then NOKEY -> shift high for exactly 1 cycle, 1 cycle after key is sampled. show_new_time is high from that cycle onward. Return to KEY_ENTRY after the release.
- In KEY_ENTRY: enter digits 1,2,3,4, then time_button for 1 cycle -> 4 single-cycle shifts, then load_new_c for 1 cycle, then SHOW_TIME with all outputs 0.
- In KEY_ENTRY with no key, 10 one_second pulses -> show_new_time drops 2 cycles after the 10th pulse, back in SHOW_TIME. A key pressed after the 9th pulse restarts the count.
- Alarm path, part 1: enter digits, then alarm_button high together with key=4'd5 -> load_new_a for 1 cycle and no shift. Alarm path, part 2: from SHOW_TIME, alarm_button held 6 cycles -> show_a high for 6 cycles, low 1 cycle after release, and keys pressed meanwhile produce no shift.
- Assert reset during KEY_WAITED with key held -> outputs go to 0 immediately, without waiting for a clock edge. After release with the key still held, KEY_STORED is entered and one shift is produced.
